// File: rtl/dpi_marshal_pkg.sv
// -----------------------------------------------------------------------------
// dpi_marshal_pkg
// Shared types and helpers for the DPI open-array marshaller.
//   state_e     : call-sequencing FSM states
//   HDR_*       : bit offsets of the fields inside the host-bound header word
//   build_hdr() : assembles the header word from func id, count, out-array flag
// -----------------------------------------------------------------------------
package dpi_marshal_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX_HDR  = 3'd1,
    S_TX_DATA = 3'd2,
    S_RX_DATA = 3'd3,
    S_RX_RET  = 3'd4,
    S_RSP     = 3'd5
  } state_e;

  localparam int HDR_FID_LSB = 16;
  localparam int HDR_N_LSB   = 8;
  localparam int HDR_OUT_BIT = 0;

  // Header layout: [31:16] func id, [15:8] element count, [7:1] zero,
  // [0] out-array flag.
  function automatic logic [31:0] build_hdr(input logic [15:0] func_id,
                                            input logic [7:0]  n,
                                            input logic        out_array);
    logic [31:0] hdr;
    hdr                       = '0;
    hdr[HDR_FID_LSB +: 16]    = func_id;
    hdr[HDR_N_LSB +: 8]       = n;
    hdr[HDR_OUT_BIT]          = out_array;
    return hdr;
  endfunction

endpackage

// File: rtl/dpi_array_marshal.sv
// -----------------------------------------------------------------------------
// dpi_array_marshal
// Serialises one DPI call (function id + open array of up to N_MAX 32-bit
// elements) into a host-bound word stream, then collects the host's reply:
// optional output-array words followed by the 32-bit return value.
// One call in flight at a time.
//
// Ports
//   clk_i, rst_ni                      clock, async active-low reset
//   req_valid_i / req_ready_o          call request handshake
//   req_func_id_i, req_n_i,
//   req_out_array_i, req_data_i        call descriptor and input array
//   tx_valid_o / tx_ready_i,
//   tx_data_o, tx_last_o               host-bound word stream
//   rx_valid_i / rx_ready_o, rx_data_i host reply words
//   rsp_valid_o / rsp_ready_i,
//   rsp_ret_o, rsp_data_o, rsp_err_o   result back to the calling logic
//
// All outputs come from registers or from a decode of the state register;
// no handshake input reaches an output combinationally.
// -----------------------------------------------------------------------------
module dpi_array_marshal
  import dpi_marshal_pkg::*;
#(
  parameter int N_MAX     = 4,
  parameter int FUNC_ID_W = 8   // at most 16: it is zero-extended into the header
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [FUNC_ID_W-1:0]  req_func_id_i,
  input  logic [7:0]            req_n_i,
  input  logic                  req_out_array_i,
  input  logic [N_MAX*32-1:0]   req_data_i,

  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [31:0]           tx_data_o,
  output logic                  tx_last_o,

  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  input  logic [31:0]           rx_data_i,

  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_ret_o,
  output logic [N_MAX*32-1:0]   rsp_data_o,
  output logic                  rsp_err_o
);

  localparam int         IDX_W   = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam logic [7:0] N_MAX_B = 8'(N_MAX);

  state_e               state_q, state_d;
  logic [FUNC_ID_W-1:0] fid_q;
  logic [7:0]           n_q;
  logic                 out_q;
  logic                 err_q;
  logic [7:0]           cnt_q;
  logic [31:0]          ret_q;
  logic [31:0]          elem_q [N_MAX];

  logic [IDX_W-1:0]     idx;
  logic                 last_elem;

  // cnt_q never reaches n_q (<= N_MAX), so the low bits always address a
  // valid element.
  assign idx       = cnt_q[IDX_W-1:0];
  // Only consulted in TX_DATA / RX_DATA, where n_q >= 1.
  assign last_elem = (cnt_q == (n_q - 8'd1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) state_d = S_TX_HDR;
      end
      S_TX_HDR: begin
        if (tx_ready_i) state_d = (n_q == 8'd0) ? S_RX_RET : S_TX_DATA;
      end
      S_TX_DATA: begin
        if (tx_ready_i && last_elem) state_d = out_q ? S_RX_DATA : S_RX_RET;
      end
      S_RX_DATA: begin
        if (rx_valid_i && last_elem) state_d = S_RX_RET;
      end
      S_RX_RET: begin
        if (rx_valid_i) state_d = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: latched call descriptor, element array, counter, return value
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fid_q <= '0;
      n_q   <= '0;
      out_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      ret_q <= '0;
      for (int i = 0; i < N_MAX; i++) elem_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            fid_q <= req_func_id_i;
            out_q <= req_out_array_i;
            cnt_q <= '0;
            // Oversized requests are clamped so the call still completes
            // with a well-formed stream; the error flag reports it.
            if (req_n_i > N_MAX_B) begin
              n_q   <= N_MAX_B;
              err_q <= 1'b1;
            end else begin
              n_q   <= req_n_i;
              err_q <= 1'b0;
            end
            for (int i = 0; i < N_MAX; i++) elem_q[i] <= req_data_i[i*32 +: 32];
          end
        end
        S_TX_DATA: begin
          if (tx_ready_i) cnt_q <= last_elem ? 8'd0 : cnt_q + 8'd1;
        end
        S_RX_DATA: begin
          if (rx_valid_i) begin
            elem_q[idx] <= rx_data_i;
            cnt_q       <= last_elem ? 8'd0 : cnt_q + 8'd1;
          end
        end
        S_RX_RET: begin
          if (rx_valid_i) ret_q <= rx_data_i;
        end
        S_RSP: begin
          if (rsp_ready_i) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: state decode plus registered values
  // ---------------------------------------------------------------------------
  assign req_ready_o = (state_q == S_IDLE);
  assign tx_valid_o  = (state_q == S_TX_HDR) || (state_q == S_TX_DATA);
  assign rx_ready_o  = (state_q == S_RX_DATA) || (state_q == S_RX_RET);
  assign rsp_valid_o = (state_q == S_RSP);
  assign rsp_ret_o   = ret_q;
  assign rsp_err_o   = err_q;

  always_comb begin
    tx_data_o = '0;
    tx_last_o = 1'b0;
    case (state_q)
      S_TX_HDR: begin
        tx_data_o = build_hdr(16'(fid_q), n_q, out_q);
        tx_last_o = (n_q == 8'd0);
      end
      S_TX_DATA: begin
        tx_data_o = elem_q[idx];
        tx_last_o = last_elem;
      end
      default: ;
    endcase
  end

  // The element array doubles as the response array: entries not
  // overwritten by the host keep their request values.
  for (genvar gi = 0; gi < N_MAX; gi++) begin : g_rsp_pack
    assign rsp_data_o[gi*32 +: 32] = elem_q[gi];
  end

endmodule

// File: tb/tb_dpi_array_marshal.sv
// -----------------------------------------------------------------------------
// tb_dpi_array_marshal
// Self-checking bench: directed call table, a reset-abort sequence and 200
// randomised calls with back-pressure, all checked against a reference model
// of the call protocol.
// -----------------------------------------------------------------------------
module tb_dpi_array_marshal;

  localparam int N_MAX = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  logic [7:0]          req_func_id_i = '0;
  logic [7:0]          req_n_i = '0;
  logic                req_out_array_i = 1'b0;
  logic [N_MAX*32-1:0] req_data_i = '0;
  logic                tx_valid_o;
  logic                tx_ready_i = 1'b0;
  logic [31:0]         tx_data_o;
  logic                tx_last_o;
  logic                rx_valid_i = 1'b0;
  logic                rx_ready_o;
  logic [31:0]         rx_data_i = '0;
  logic                rsp_valid_o;
  logic                rsp_ready_i = 1'b0;
  logic [31:0]         rsp_ret_o;
  logic [N_MAX*32-1:0] rsp_data_o;
  logic                rsp_err_o;

  dpi_array_marshal #(.N_MAX(N_MAX), .FUNC_ID_W(8)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_func_id_i   (req_func_id_i),
    .req_n_i         (req_n_i),
    .req_out_array_i (req_out_array_i),
    .req_data_i      (req_data_i),
    .tx_valid_o      (tx_valid_o),
    .tx_ready_i      (tx_ready_i),
    .tx_data_o       (tx_data_o),
    .tx_last_o       (tx_last_o),
    .rx_valid_i      (rx_valid_i),
    .rx_ready_o      (rx_ready_o),
    .rx_data_i       (rx_data_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_ret_o       (rsp_ret_o),
    .rsp_data_o      (rsp_data_o),
    .rsp_err_o       (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Host-side reply words still to be delivered, and what the bench saw.
  logic [31:0]  host_q[$];
  logic [31:0]  obs_tx[$];
  logic         obs_last[$];
  logic [31:0]  obs_ret;
  logic [127:0] obs_data;
  logic         obs_err;
  int           obs_lat;

  typedef struct {
    logic [7:0]        fid;
    logic [7:0]        n;
    logic              outa;
    logic [127:0]      data;
    logic [4:0][31:0]  w;       // host reply words in send order
    logic [31:0]       e_hdr;
    logic [31:0]       e_ret;
    logic [127:0]      e_data;
    logic              e_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] out_bundle();
    return 256'({req_ready_o, tx_valid_o, tx_data_o, tx_last_o, rx_ready_o,
                 rsp_valid_o, rsp_ret_o, rsp_data_o, rsp_err_o});
  endfunction

  localparam logic [197:0] RESET_BUNDLE = {1'b1, 197'd0};

  // Drives one call through the DUT; host_q must already hold the reply.
  task automatic run_call(input logic [7:0] fid, input logic [7:0] n, input logic outa,
                          input logic [127:0] data, input bit bp);
    int           cyc;
    bit           done, tx_stall, rsp_seen;
    logic [32:0]  stall_w;
    logic [160:0] rsp_w;
    obs_tx.delete();
    obs_last.delete();
    req_valid_i = 1'b1; req_func_id_i = fid; req_n_i = n;
    req_out_array_i = outa; req_data_i = data;
    cyc = 0;
    while (!req_ready_o && cyc < 20) begin step(); cyc++; end
    step();
    req_valid_i = 1'b0;
    cyc = 1; done = 0; tx_stall = 0; rsp_seen = 0; stall_w = '0; rsp_w = '0;
    while (!done && cyc < 400) begin
      if (tx_stall)
        chk("tx_stable", 256'({tx_valid_o, tx_last_o, tx_data_o}), 256'({1'b1, stall_w}));
      tx_ready_i = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      tx_stall = 0;
      if (tx_valid_o) begin
        if (tx_ready_i) begin
          obs_tx.push_back(tx_data_o);
          obs_last.push_back(tx_last_o);
        end else begin
          tx_stall = 1;
          stall_w = {tx_last_o, tx_data_o};
        end
      end
      rx_valid_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_data_i  = (host_q.size() > 0) ? host_q[0] : $urandom;
      if (rx_valid_i && rx_ready_o && host_q.size() > 0) void'(host_q.pop_front());
      rsp_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rsp_valid_o) begin
        if (!rsp_seen) begin
          rsp_seen = 1;
          obs_lat = cyc;
          rsp_w = {rsp_ret_o, rsp_data_o, rsp_err_o};
        end else begin
          chk("rsp_stable", 256'({rsp_ret_o, rsp_data_o, rsp_err_o}), 256'(rsp_w));
        end
        if (!bp) rsp_ready_i = 1'b1;
        if (rsp_ready_i) begin
          done = 1;
          chk("no_b2b_accept", 256'(req_ready_o), 256'(0));
        end
      end
      step();
      cyc++;
    end
    tx_ready_i = 1'b0; rx_valid_i = 1'b0; rsp_ready_i = 1'b0;
    if (!done) chk("call_timeout", 256'(0), 256'(1));
    chk("idle_after_rsp", 256'({req_ready_o, rsp_valid_o, rsp_err_o}), 256'(3'b100));
    obs_ret  = rsp_w[160:129];
    obs_data = rsp_w[128:1];
    obs_err  = rsp_w[0];
  endtask

  // Reference model: expected stream and response from the protocol rules.
  task automatic do_call(input logic [7:0] fid, input logic [7:0] n, input logic outa,
                         input logic [127:0] data, input logic [4:0][31:0] w, input bit bp);
    int           nn, nw;
    logic [31:0]  hdr, exp_w, exp_ret;
    logic [127:0] exp_data;
    nn = (n > 8'(N_MAX)) ? N_MAX : int'(n);
    nw = (outa && nn > 0) ? nn + 1 : 1;
    host_q.delete();
    for (int i = 0; i < nw; i++) host_q.push_back(w[i]);
    hdr = (32'(fid) << 16) | (32'(nn) << 8) | 32'(outa);
    exp_data = data;
    if (outa) for (int i = 0; i < nn; i++) exp_data[i*32 +: 32] = w[i];
    exp_ret = w[nw-1];

    run_call(fid, n, outa, data, bp);

    chk("tx_count", 256'(obs_tx.size()), 256'(nn + 1));
    for (int i = 0; i <= nn && i < obs_tx.size(); i++) begin
      exp_w = (i == 0) ? hdr : data[(i-1)*32 +: 32];
      chk("tx_word", 256'(obs_tx[i]), 256'(exp_w));
      chk("tx_last", 256'(obs_last[i]), 256'(i == nn));
    end
    chk("host_drained", 256'(host_q.size()), 256'(0));
    chk("rsp_ret",  256'(obs_ret),  256'(exp_ret));
    chk("rsp_data", 256'(obs_data), 256'(exp_data));
    chk("rsp_err",  256'(obs_err),  256'(n > 8'(N_MAX)));
    if (!bp) chk("latency", 256'(obs_lat), 256'(3 + nn + (outa ? nn : 0)));
  endtask

  initial begin
    logic [127:0]     d0, rd;
    logic [4:0][31:0] rw;
    int               cyc;

    d0 = 128'hDEADBEEF_CAFEBABE_12345678_9ABCDEF0;

    vecs[0] = '{fid: 8'h01, n: 8'd4, outa: 1'b0, data: d0, w: '0,
                e_hdr: 32'h0001_0400, e_ret: 32'h1234, e_data: d0, e_err: 1'b0};
    vecs[0].w[0] = 32'h1234;
    vecs[1] = '{fid: 8'h02, n: 8'd4, outa: 1'b1, data: d0, w: '0,
                e_hdr: 32'h0002_0401, e_ret: 32'd4,
                e_data: 128'h00000003_00000002_00000001_00000000, e_err: 1'b0};
    for (int i = 0; i < 5; i++) vecs[1].w[i] = 32'(i);
    vecs[2] = '{fid: 8'h03, n: 8'd0, outa: 1'b1, data: d0, w: '0,
                e_hdr: 32'h0003_0001, e_ret: 32'h77, e_data: d0, e_err: 1'b0};
    vecs[2].w[0] = 32'h77;
    vecs[3] = '{fid: 8'hAB, n: 8'd6, outa: 1'b0, data: d0, w: '0,
                e_hdr: 32'h00AB_0400, e_ret: 32'h55, e_data: d0, e_err: 1'b1};
    vecs[3].w[0] = 32'h55;
    vecs[4] = '{fid: 8'h05, n: 8'd6, outa: 1'b1, data: d0, w: '0,
                e_hdr: 32'h0005_0401, e_ret: 32'hA4,
                e_data: 128'h000000A3_000000A2_000000A1_000000A0, e_err: 1'b1};
    for (int i = 0; i < 5; i++) vecs[4].w[i] = 32'hA0 + 32'(i);
    vecs[5] = '{fid: 8'hFF, n: 8'd3, outa: 1'b1, data: d0, w: '0,
                e_hdr: 32'h00FF_0301, e_ret: 32'hB3,
                e_data: 128'hDEADBEEF_000000B2_000000B1_000000B0, e_err: 1'b0};
    for (int i = 0; i < 4; i++) vecs[5].w[i] = 32'hB0 + 32'(i);

    // Reset state
    #12;
    chk("reset_outputs", out_bundle(), 256'(RESET_BUNDLE));
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    chk("ready_after_reset", 256'(req_ready_o), 256'(1));

    // Directed table, peers always ready
    for (int v = 0; v < 6; v++) begin
      do_call(vecs[v].fid, vecs[v].n, vecs[v].outa, vecs[v].data, vecs[v].w, 1'b0);
      chk("vec_hdr",  256'((obs_tx.size() > 0) ? obs_tx[0] : 32'hX), 256'(vecs[v].e_hdr));
      chk("vec_ret",  256'(obs_ret),  256'(vecs[v].e_ret));
      chk("vec_data", 256'(obs_data), 256'(vecs[v].e_data));
      chk("vec_err",  256'(obs_err),  256'(vecs[v].e_err));
      $display("vec %0d: fid=%0h n=%0d out=%0d hdr=%08h ret=%08h err=%0d",
               v, vecs[v].fid, vecs[v].n, vecs[v].outa, obs_tx[0], obs_ret, obs_err);
    end

    // Reset during RxData after two reply words
    req_valid_i = 1'b1; req_func_id_i = 8'h09; req_n_i = 8'd4;
    req_out_array_i = 1'b1; req_data_i = d0;
    step();
    req_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    cyc = 0;
    while (!rx_ready_o && cyc < 50) begin step(); cyc++; end
    tx_ready_i = 1'b0;
    if (!rx_ready_o) chk("rst_seq_timeout", 256'(0), 256'(1));
    rx_valid_i = 1'b1; rx_data_i = 32'h11;
    step();
    rx_data_i = 32'h22;
    step();
    rx_valid_i = 1'b0;
    chk("midcall_in_rx", 256'({rx_ready_o, tx_valid_o, rsp_valid_o}), 256'(3'b100));
    rst_ni = 1'b0;
    #1;
    chk("rst_abort_outputs", out_bundle(), 256'(RESET_BUNDLE));
    step();
    step();
    chk("rst_held_outputs", out_bundle(), 256'(RESET_BUNDLE));
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    chk("ready_after_abort", 256'(req_ready_o), 256'(1));
    $display("reset abort: outputs cleared, req_ready=%0d", req_ready_o);
    do_call(vecs[1].fid, vecs[1].n, vecs[1].outa, vecs[1].data, vecs[1].w, 1'b0);
    $display("post-reset call: ret=%08h data=%032h", obs_ret, obs_data);

    // Randomised calls with back-pressure on every port
    for (int c = 0; c < 200; c++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 5; i++) rw[i] = $urandom;
      do_call(8'($urandom), 8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), rd, rw, 1'b1);
      $display("rand %0d: hdr=%08h words=%0d ret=%08h err=%0d",
               c, obs_tx[0], obs_tx.size(), obs_ret, obs_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
